// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the I/O decoder port; all outputs registered.
// Optional bus lock is compiled in with `define IO_ARB_LOCK_EN.
module io_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
`ifdef IO_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic        io_ce,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_din,
  input  logic [31:0] io_dout,
  output logic        grant
);

  if (ACCESS_CYCLES == 0 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $fatal(1, "io_bus_arbiter: ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req_any, win;
  logic        ce_nxt, we_nxt, grant_nxt, ack0_nxt, ack1_nxt;
  logic [31:0] addr_nxt, din_nxt, rdata0_nxt, rdata1_nxt;
`ifdef IO_ARB_LOCK_EN
  logic        lock_q, lock_nxt;
`endif

  // Winner selection: a lone requester wins, contention goes to the other master.
  always_comb begin
    req_any = m0_req | m1_req;
    win     = m1_req;
    if (m0_req && m1_req) win = ~grant;
`ifdef IO_ARB_LOCK_EN
    if (lock_q) begin
      req_any = grant ? m1_req : m0_req;
      win     = grant;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ce_nxt     = io_ce;
    we_nxt     = io_we;
    addr_nxt   = io_addr;
    din_nxt    = io_din;
    grant_nxt  = grant;
    cnt_nxt    = cnt;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    rdata0_nxt = m0_rdata;
    rdata1_nxt = m1_rdata;
`ifdef IO_ARB_LOCK_EN
    lock_nxt   = lock_q;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_nxt = win;
          ce_nxt    = 1'b1;
          we_nxt    = win ? m1_we    : m0_we;
          addr_nxt  = win ? m1_addr  : m0_addr;
          din_nxt   = win ? m1_wdata : m0_wdata;
          cnt_nxt   = CNT_INIT;
        end
      end
      ACCESS: begin
        // Write strobe lasts one cycle so side-effecting registers fire once.
        we_nxt = 1'b0;
        if (cnt == 4'd0) begin
          ce_nxt   = 1'b0;
          addr_nxt = IDLE_ADDR;
          din_nxt  = '0;
          if (grant) begin
            rdata1_nxt = io_dout;
            ack1_nxt   = 1'b1;
          end else begin
            rdata0_nxt = io_dout;
            ack0_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
`ifdef IO_ARB_LOCK_EN
      RESP: lock_nxt = grant ? m1_lock : m0_lock;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_ce    <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= IDLE_ADDR;
      io_din   <= '0;
      grant    <= 1'b1;
      cnt      <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
`ifdef IO_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      io_ce    <= ce_nxt;
      io_we    <= we_nxt;
      io_addr  <= addr_nxt;
      io_din   <= din_nxt;
      grant    <= grant_nxt;
      cnt      <= cnt_nxt;
      m0_ack   <= ack0_nxt;
      m1_ack   <= ack1_nxt;
      m0_rdata <= rdata0_nxt;
      m1_rdata <= rdata1_nxt;
`ifdef IO_ARB_LOCK_EN
      lock_q   <= lock_nxt;
`endif
    end
  end

endmodule
